mmio_responder: RTL and testbench
=================================

MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 The module SHALL have parameter RAM_WORDS, default 256, which sets the number of 32-bit data RAM words (power of two, at most 1024).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port addr, input, 32 bits: byte address from the CPU MEM stage; addr[1:0] ignored.
REQ-005 The module SHALL have port wdata, input, 32 bits: store data.
REQ-006 The module SHALL have port mem_read, input, 1 bit: load request, this cycle.
REQ-007 The module SHALL have port mem_write, input, 1 bit: store request, committed at the next rising edge.
REQ-008 The module SHALL have port rdata, output, 32 bits: load data, combinational.
REQ-009 The module SHALL have port led, output, 8 bits: LED register.
REQ-010 The module SHALL have port digi, output, 12 bits: seven-segment drive register (anode and segment bits).
REQ-011 The module SHALL have port irq, output, 1 bit: timer interrupt, equal to TCON[2].

Function
REQ-012 Address map, word granular:
- RAM at 0x0000_0000 up to RAM_WORDS*4-1, indexed by addr[log2(RAM_WORDS)+1:2].
- TH at 0x4000_0000.
- TL at 0x4000_0004.
- TCON[2:0] at 0x4000_0008.
- LED at 0x4000_000C.
- DIGI at 0x4000_0010.
- SYSTICK at 0x4000_0014.
REQ-013 rdata SHALL be 0 when mem_read=0 or when addr is unmapped. Otherwise it SHALL be the addressed content, zero-extended for narrow registers, with no wait states.
REQ-014 When mem_write=1, the store SHALL update the addressed location at the rising edge. Writes to unmapped addresses or to SYSTICK SHALL be silently discarded.
REQ-015 If mem_read and mem_write are both 1, rdata SHALL show the pre-write value. The write SHALL commit at the edge.
REQ-016 SYSTICK SHALL increment by 1 every cycle, wrapping from 0xFFFF_FFFF to 0.
REQ-017 Timer, evaluated each edge when TCON[0]=1:
- If TL==0xFFFF_FFFF: TL<=TH, and if TCON[1]=1, TCON[2]<=1.
- Otherwise: TL<=TL+1.
REQ-018 When TCON[0]=0, TL SHALL hold its value and TCON[2] SHALL hold its value.
REQ-019 TCON[2] SHALL be sticky. It clears only by a CPU write of TCON with wdata[2]=0.
REQ-020 A CPU write to TL SHALL override the timer update of the same edge.
REQ-021 A CPU write to TCON SHALL override an overflow setting TCON[2] on the same edge, so the written value wins.
REQ-022 A CPU write to TH in the same cycle as an overflow SHALL cause TL to load the old TH. The new TH SHALL take effect from the next overflow.
REQ-023 irq SHALL be a registered signal equal to TCON[2], with no combinational path from inputs.
REQ-024 led SHALL equal the LED register [7:0], and digi SHALL equal the DIGI register [11:0], both driven directly from registers.

Reset
REQ-025 While reset=0:
- TH, TL, TCON, LED, DIGI and SYSTICK SHALL be 0 immediately, without waiting for clk.
- led=0, digi=0, irq=0.
REQ-026 RAM contents SHALL NOT be cleared by reset. RAM stays implementable as block RAM; reads before any write are undefined.
REQ-027 Reset asserted mid-count SHALL abort the timer. After release, counting SHALL resume only after software rewrites TCON[0]=1.
REQ-028 After reset deasserts, the first edge SHALL advance SYSTICK to 1.

Verification
REQ-029 RAM: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 -> rdata=0xDEADBEEF for both. Load 0x0000_0014 after storing 0x1 there -> 0x0000_0001.
REQ-030 Timer reload and irq: set TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, then TCON=3 -> TL goes 0xFFFF_FFFF, then 0xFFFF_FFFC; irq=1 on that same edge; TL continues to 0xFFFF_FFFD. Write TCON=3 -> irq=0 while counting continues.
REQ-031 Collisions: at the overflow edge, write TL=0x5 -> TL=0x5 and irq still set if TCON[1]=1. Repeat with a write of TCON=1 at the overflow edge -> TCON=1, irq=0.
REQ-032 Peripherals and unmapped space:
- Write LED=0x1A5 -> led=0xA5.
- Write DIGI=0xFFFF -> digi=0xFFF.
- Write then read 0x5000_0000 -> rdata=0, and no register changes.
- Write SYSTICK -> no effect.
- Any load with mem_read=0 -> rdata=0.
REQ-033 Async reset: run the timer and SYSTICK to a nonzero state, then pulse reset low between clock edges -> all registers, led, digi and irq are 0 before the next edge. The RAM word stored earlier is still readable after reset.

Source files
------------

// File: rtl/mmio_responder.sv
// Memory-mapped responder for a small CPU: word-addressed data RAM plus timer,
// LED, seven-segment and free-running SYSTICK registers.
module mmio_responder #(
    parameter int unsigned RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;

    logic sel_ram, sel_th, sel_tl, sel_tcon, sel_led, sel_digi, sel_systick;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q, systick_d;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign ram_idx = addr[AW+1:2];

    always_comb begin
        sel_ram     = (addr[31:AW+2] == '0);
        sel_th      = (addr[31:2] == 30'h1000_0000);
        sel_tl      = (addr[31:2] == 30'h1000_0001);
        sel_tcon    = (addr[31:2] == 30'h1000_0002);
        sel_led     = (addr[31:2] == 30'h1000_0003);
        sel_digi    = (addr[31:2] == 30'h1000_0004);
        sel_systick = (addr[31:2] == 30'h1000_0005);
    end

    // Read mux shows pre-write contents; stores only land at the edge.
    always_comb begin
        rdata = '0;
        if (mem_read) begin
            if (sel_ram)          rdata = ram[ram_idx];
            else if (sel_th)      rdata = th_q;
            else if (sel_tl)      rdata = tl_q;
            else if (sel_tcon)    rdata = {29'd0, tcon_q};
            else if (sel_led)     rdata = {24'd0, led_q};
            else if (sel_digi)    rdata = {20'd0, digi_q};
            else if (sel_systick) rdata = systick_q;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_write && sel_ram) ram[ram_idx] <= wdata;
    end

    // Timer update first, then CPU stores override the same-edge result.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[0]) begin
            if (tl_q == '1) begin
                tl_d = th_q;
                if (tcon_q[1]) tcon_d[2] = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (mem_write) begin
            if (sel_th)   th_d   = wdata;
            if (sel_tl)   tl_d   = wdata;
            if (sel_tcon) tcon_d = wdata[2:0];
            if (sel_led)  led_d  = wdata[7:0];
            if (sel_digi) digi_d = wdata[11:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    assign led  = led_q;
    assign digi = digi_q;
    assign irq  = tcon_q[2];

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder: RAM, timer collisions,
// peripherals, unmapped space and asynchronous reset.
module tb_mmio_responder;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] tick_m;

    mmio_responder #(.RAM_WORDS(256)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata),
        .led(led), .digi(digi), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference SYSTICK: edges seen since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) tick_m <= '0;
        else        tick_m <= tick_m + 32'd1;
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; mem_write = 1'b1; mem_read = 1'b0;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; mem_read = 1'b1;
        #1;
        d = rdata;
        mem_read = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({led, digi, irq} !== 21'd0) begin n_err++; $display("FAIL rst_outs: got %h want 0", {led, digi, irq}); end
        rd(A_TH, d);   n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_th: got %h want 0", d); end
        rd(A_TL, d);   n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_tl: got %h want 0", d); end
        rd(A_TCON, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_tcon: got %h want 0", d); end
        rd(A_TICK, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_systick: got %h want 0", d); end
        @(negedge clk) reset = 1'b1;
        tick(1);
        rd(A_TICK, d); n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL systick_first: got %h want 1", d); end
        tick(2);
        rd(A_TICK, d); n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL systick_three: got %h want 3", d); end
    endtask

    task automatic test_ram;
        logic [31:0] d;
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, d); n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_10: got %h want deadbeef", d); end
        rd(32'h13, d); n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_13: got %h want deadbeef", d); end
        wr(32'h14, 32'h1);
        rd(32'h14, d); n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL ram_14: got %h want 1", d); end
        rd(32'h10, d); n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_10_kept: got %h want deadbeef", d); end
        wr(32'h3FC, 32'hA5A5_5A5A);
        rd(32'h3FC, d); n_vec++; if (d !== 32'hA5A5_5A5A) begin n_err++; $display("FAIL ram_last: got %h want a5a55a5a", d); end
        rd(32'h400, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ram_beyond: got %h want 0", d); end
    endtask

    task automatic test_read_during_write;
        @(negedge clk);
        addr = 32'h10; wdata = 32'h1234_5678; mem_write = 1'b1; mem_read = 1'b1;
        #1;
        n_vec++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rdw_old: got %h want deadbeef", rdata); end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        #1;
        n_vec++; if (rdata !== 32'h1234_5678) begin n_err++; $display("FAIL rdw_new: got %h want 12345678", rdata); end
        mem_read = 1'b0;
    endtask

    task automatic test_timer;
        logic [31:0] d;
        wr(A_TCON, 32'd0);
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'd3);
        rd(A_TL, d); n_vec++; if (d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL tmr_start: got %h want fffffffe", d); end
        tick(1);
        rd(A_TL, d); n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL tmr_ff: got %h want ffffffff", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL tmr_irq_pre: got %b want 0", irq); end
        tick(1);
        rd(A_TL, d); n_vec++; if (d !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL tmr_reload: got %h want fffffffc", d); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tmr_irq_set: got %b want 1", irq); end
        tick(1);
        rd(A_TL, d); n_vec++; if (d !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL tmr_cont: got %h want fffffffd", d); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tmr_irq_sticky: got %b want 1", irq); end
        wr(A_TCON, 32'd3);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL tmr_irq_clr: got %b want 0", irq); end
        rd(A_TL, d); n_vec++; if (d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL tmr_after_clr: got %h want fffffffe", d); end
        tick(1);
        // This TCON write lands on an overflow edge: written 0 beats the irq set.
        wr(A_TCON, 32'd0);
        rd(A_TL, d); n_vec++; if (d !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL tmr_stop_reload: got %h want fffffffc", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL tmr_stop_irq: got %b want 0", irq); end
        tick(3);
        rd(A_TL, d); n_vec++; if (d !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL tmr_hold: got %h want fffffffc", d); end
        wr(A_TCON, 32'd4);
        tick(3);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tmr_irq_hold: got %b want 1", irq); end
        rd(A_TL, d); n_vec++; if (d !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL tmr_hold2: got %h want fffffffc", d); end
    endtask

    task automatic test_collisions;
        logic [31:0] d;
        wr(A_TCON, 32'd0);
        wr(A_TH, 32'h100);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'd3);
        tick(1);
        wr(A_TL, 32'h5);
        rd(A_TL, d); n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL col_tl: got %h want 5", d); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL col_tl_irq: got %b want 1", irq); end
        tick(1);
        rd(A_TL, d); n_vec++; if (d !== 32'h6) begin n_err++; $display("FAIL col_tl_next: got %h want 6", d); end
        wr(A_TCON, 32'd0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'd3);
        tick(1);
        wr(A_TCON, 32'd1);
        rd(A_TCON, d); n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL col_tcon: got %h want 1", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL col_tcon_irq: got %b want 0", irq); end
        rd(A_TL, d); n_vec++; if (d !== 32'h100) begin n_err++; $display("FAIL col_tcon_tl: got %h want 100", d); end
        wr(A_TL, 32'hFFFF_FFFE);
        tick(1);
        wr(A_TH, 32'h200);
        rd(A_TL, d); n_vec++; if (d !== 32'h100) begin n_err++; $display("FAIL col_th_old: got %h want 100", d); end
        rd(A_TH, d); n_vec++; if (d !== 32'h200) begin n_err++; $display("FAIL col_th_new: got %h want 200", d); end
        wr(A_TL, 32'hFFFF_FFFF);
        tick(1);
        rd(A_TL, d); n_vec++; if (d !== 32'h200) begin n_err++; $display("FAIL col_th_next: got %h want 200", d); end
    endtask

    task automatic test_peripherals;
        logic [31:0] d;
        wr(A_LED, 32'h1A5);
        n_vec++; if (led !== 8'hA5) begin n_err++; $display("FAIL led_out: got %h want a5", led); end
        rd(A_LED, d); n_vec++; if (d !== 32'hA5) begin n_err++; $display("FAIL led_rd: got %h want a5", d); end
        wr(A_DIGI, 32'hFFFF);
        n_vec++; if (digi !== 12'hFFF) begin n_err++; $display("FAIL digi_out: got %h want fff", digi); end
        rd(A_DIGI, d); n_vec++; if (d !== 32'hFFF) begin n_err++; $display("FAIL digi_rd: got %h want fff", d); end
        wr(32'h5000_0000, 32'hFFFF_FFFF);
        rd(32'h5000_0000, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL unmap_rd: got %h want 0", d); end
        n_vec++; if ({led, digi} !== 20'hA5FFF) begin n_err++; $display("FAIL unmap_regs: got %h want a5fff", {led, digi}); end
        rd(A_TH, d); n_vec++; if (d !== 32'h200) begin n_err++; $display("FAIL unmap_th: got %h want 200", d); end
        rd(32'h4000_0018, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL unmap_18: got %h want 0", d); end
        wr(A_TICK, 32'd0);
        rd(A_TICK, d); n_vec++; if (d !== tick_m) begin n_err++; $display("FAIL systick_wr: got %h want %h", d, tick_m); end
        addr = A_LED; mem_read = 1'b0;
        #1;
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL no_read: got %h want 0", rdata); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        wr(A_TCON, 32'd7);
        tick(2);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({led, digi, irq} !== 21'd0) begin n_err++; $display("FAIL areset_outs: got %h want 0", {led, digi, irq}); end
        rd(A_TL, d);   n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL areset_tl: got %h want 0", d); end
        rd(A_TH, d);   n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL areset_th: got %h want 0", d); end
        rd(A_TICK, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL areset_systick: got %h want 0", d); end
        rd(32'h10, d); n_vec++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL areset_ram: got %h want 12345678", d); end
        @(negedge clk) reset = 1'b1;
        tick(1);
        rd(A_TICK, d); n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL areset_systick1: got %h want 1", d); end
        tick(3);
        rd(A_TL, d);   n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL areset_tl_idle: got %h want 0", d); end
        rd(A_TCON, d); n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL areset_tcon: got %h want 0", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_ram;
        test_read_during_write;
        test_timer;
        test_collisions;
        test_peripherals;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
